// File: rtl/seg7_pkg.sv
// Shared constants and hex decode for the scanned 7-segment display.
// Segment bits are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg7_hex(
    input logic [3:0] nibble
  );
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/seg7_lzb_mask.sv
// Leading-zero blank mask: bit i set when digits i..top are all zero.
// Digit 0 always stays visible so a zero value still shows "0".
module seg7_lzb_mask #(
  parameter int DIGITS = 4
) (
  input  logic [DIGITS*4-1:0] nibbles,
  input  logic                en,
  output logic [DIGITS-1:0]   mask
);

  logic zero_run;

  always_comb begin
    zero_run = 1'b1;
    mask     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (nibbles[i*4 +: 4] == 4'h0);
      mask[i]  = en && zero_run && (i != 0);
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multi-channel 7-segment scan controller with frame snapshots,
// leading-zero blanking, blink, decimal points and anode dead time.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int CHANNELS     = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64,
  localparam int SEL_W =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [CHANNELS*DIGITS*4-1:0] ChanData,
  input  logic [SEL_W-1:0]             ChanSel,
  input  logic                         LzbEn,
  input  logic [DIGITS-1:0]            BlinkMask,
  input  logic [DIGITS-1:0]            DpIn,
  output logic [7:0]                   SegOut,
  output logic [DIGITS-1:0]            Bits,
  output logic                         FrameDone
);

  localparam int W     = DIGITS * 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FR_W  =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [FR_W-1:0]  FR_TOP = FR_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [FR_W-1:0]   frm;
  logic              blink;
  logic              armed;
  logic [W-1:0]      snap_data;
  logic              snap_lzb;
  logic [DIGITS-1:0] snap_blink;
  logic [DIGITS-1:0] snap_dp;

  logic              tick;
  logic              frame_end;
  logic              take;
  logic [W-1:0]      sel_word;
  logic [DIGITS-1:0] lzb_mask;
  logic [3:0]        nib;
  logic              dp_bit;
  logic              blank_bit;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] bits_d;

  assign tick      = (cnt == CNT_TOP);
  assign frame_end = tick && (idx == LAST);
  // First cycle out of reset grabs a fresh snapshot too.
  assign take      = frame_end || !armed;

  always_comb begin
    sel_word = ChanData[W-1:0];
    for (int c = 1; c < CHANNELS; c++) begin
      if (ChanSel == SEL_W'(c)) sel_word = ChanData[c*W +: W];
    end
  end

  seg7_lzb_mask #(
    .DIGITS (DIGITS)
  ) u_lzb (
    .nibbles (snap_data),
    .en      (snap_lzb),
    .mask    (lzb_mask)
  );

  always_comb begin
    nib       = 4'h0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = snap_data[i*4 +: 4];
        dp_bit    = snap_dp[i];
        blank_bit = lzb_mask[i] | (blink & snap_blink[i]);
      end
    end
  end

  always_comb begin
    seg_d  = blank_bit ? SEG_BLANK : {~dp_bit, seg7_hex(nib)};
    bits_d = ~(DIGITS'(1) << idx);
    if (cnt < CNT_DEAD) begin
      seg_d  = SEG_BLANK;
      bits_d = '1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt   <= '0;
      idx   <= '0;
      frm   <= '0;
      blink <= 1'b0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      cnt   <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == LAST) ? '0 : idx + 1'b1;
      if (frame_end) begin
        if (frm == FR_TOP) begin
          frm   <= '0;
          blink <= ~blink;
        end else begin
          frm <= frm + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      snap_data  <= '0;
      snap_lzb   <= 1'b0;
      snap_blink <= '0;
      snap_dp    <= '0;
    end else if (take) begin
      snap_data  <= sel_word;
      snap_lzb   <= LzbEn;
      snap_blink <= BlinkMask;
      snap_dp    <= DpIn;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      SegOut    <= SEG_BLANK;
      Bits      <= '1;
      FrameDone <= 1'b0;
    end else begin
      SegOut    <= seg_d;
      Bits      <= bits_d;
      FrameDone <= frame_end;
    end
  end

endmodule
